bin2dec_char_gen: RTL
=====================

// Module: bin2dec_char_gen
// PURPOSE
//  Sequential binary-to-decimal converter for on-screen numeric fields. Accepts a
//  WIDTH-bit binary value and converts it with shift-add-3 (double dabble), one bit
//  per clock. Emits DIGITS BCD digits plus one char-ROM glyph address per digit,
//  with optional leading-zero blanking. Sits between value producers (counters,
//  sensors) and the char ROM / screen-field writer.
// PARAMETERS
//  WIDTH      8     binary input width, >=1
//  DIGITS     3     decimal digits out; must be >= ceil(WIDTH*log10(2)), checked at elaboration
//  ADDR_W     8     char-ROM glyph address width
//  ZERO_CODE  8'h30 glyph address of '0'; digit d maps to ZERO_CODE+d
//  BLANK_CODE 8'h20 glyph address of blank (space)
// PORTS
//  clk        in   1               system clock, rising edge
//  rst_n      in   1               asynchronous active-low reset
//  in_valid   in   1               request: in_value/in_blank_lz are valid
//  in_ready   out  1               block idle, can accept a value
//  in_value   in   WIDTH           binary value to convert
//  in_blank_lz in  1               1 = blank leading zeros for this value
//  out_valid  out  1               result valid, held until accepted
//  out_ready  in   1               consumer accepts result
//  out_bcd    out  4*DIGITS        BCD digits; [3:0] = least significant digit
//  out_char   out  ADDR_W*DIGITS   glyph addresses; [ADDR_W-1:0] = least significant digit
//  busy       out  1               conversion in progress (state SHIFT)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, out_valid=0, busy=0, out_bcd=0,
//    every out_char slot = BLANK_CODE, bit counter=0. in_ready=1 once in IDLE.
//  - FSM IDLE -> SHIFT -> HOLD -> IDLE. in_ready = (state==IDLE); busy = (state==SHIFT).
//  - IDLE: in_valid&&in_ready -> latch in_value into shift reg, latch in_blank_lz,
//    clear BCD accumulator, counter=0, go SHIFT.
//  - SHIFT, each cycle: each BCD digit >=5 gets +3 (all digits in parallel), then
//    {bcd,shift} <<= 1. After exactly WIDTH cycles (counter==WIDTH-1) go HOLD.
//  - On SHIFT->HOLD edge, register out_bcd and out_char together; out_valid=1 in
//    HOLD. Latency: accept edge to out_valid high = WIDTH+1 clocks.
//  - out_char[i] = ZERO_CODE+digit[i], except when blank_lz=1 and digit i and all
//    more-significant digits are 0 -> BLANK_CODE. Digit 0 is never blanked (value 0 shows "0").
//  - HOLD: out_bcd/out_char/out_valid stable until out_valid&&out_ready; then out_valid=0,
//    go IDLE; outputs keep last result. No new input in the handshake cycle
//    (in_ready rises the next cycle). Throughput: one value per WIDTH+2 clocks.
//  - in_valid outside IDLE is ignored (no queueing). Inputs not sampled outside IDLE accept.
//  - Carry out of top digit impossible given the DIGITS check; no overflow flag.
//  - rst_n low in any state aborts immediately to reset values; partial result discarded.
//  - Add-3 adjust per digit: 4-bit in -> 4-bit out, (d>=5) ? d+3 : d, mod 16.
// STRUCTURE
//  - Shared package/header char_rom_pkg: ZERO_CODE/BLANK_CODE defaults, FSM state
//    encoding (IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2), digit-to-glyph function.
//  - Sub-module dd_add3 (combinational digit adjust), instantiated DIGITS times by
//    generate loop. FSM, counter ($clog2(WIDTH+1) bits), shift reg and output
//    regs in the top.
// TESTING
//  1 Reset: rst_n=0 -> out_valid=0, in_ready=1, busy=0, out_bcd=0, out_char all 8'h20.
//  2 in_value=255, blank_lz=0 (defaults) -> after 9 clocks out_bcd=12'h255,
//    out_char={8'h32,8'h35,8'h35}.
//  3 in_value=7: blank_lz=1 -> out_char={8'h20,8'h20,8'h37}; blank_lz=0 ->
//    {8'h30,8'h30,8'h37}; in_value=0, blank_lz=1 -> {8'h20,8'h20,8'h30}.
//  4 Backpressure: out_ready=0 for 5 clocks in HOLD -> outputs stable, in_ready=0,
//    extra in_valid ignored; out_ready=1 -> out_valid=0 next clock, in_ready=1.
//  5 Reset mid-SHIFT (cycle 3 of 8) -> immediate reset values; next value 100 ->
//    out_bcd=12'h100.
//  6 WIDTH=4, DIGITS=2: counter sweeps 0..15 back-to-back -> out_bcd 8'h00..8'h15,
//    each latency 5, no value dropped or duplicated.

Source files
------------

// File: rtl/char_rom_pkg.sv
// Shared definitions for the binary-to-decimal glyph path: default glyph codes,
// converter FSM encoding and helpers for digit sizing and digit-to-glyph mapping.
package char_rom_pkg;

  localparam logic [7:0] ZeroCodeDefault  = 8'h30;
  localparam logic [7:0] BlankCodeDefault = 8'h20;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  // ceil(width * log10(2)) using a fixed-point approximation of log10(2)
  function automatic int unsigned min_digits(int unsigned width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic int unsigned digit_glyph(int unsigned zero_code, logic [3:0] digit);
    return zero_code + 32'(digit);
  endfunction

endpackage

// File: rtl/dd_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 before the next shift.
module dd_add3 (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2dec_char_gen.sv
// Sequential binary-to-BCD converter (one bit per clock) that also emits one
// char-ROM glyph address per digit, with optional leading-zero blanking.
module bin2dec_char_gen
  import char_rom_pkg::*;
#(
  parameter int unsigned       WIDTH      = 8,
  parameter int unsigned       DIGITS     = 3,
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] ZERO_CODE  = ADDR_W'(ZeroCodeDefault),
  parameter logic [ADDR_W-1:0] BLANK_CODE = ADDR_W'(BlankCodeDefault)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_value,
  input  logic                     in_blank_lz,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*DIGITS-1:0]      out_bcd,
  output logic [ADDR_W*DIGITS-1:0] out_char,
  output logic                     busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam int unsigned      BCD_W    = 4 * DIGITS;
  localparam int unsigned      CHAR_W   = ADDR_W * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  if (WIDTH == 0 || DIGITS < min_digits(WIDTH)) begin : g_param_check
    $error("bin2dec_char_gen: DIGITS too small to hold a WIDTH-bit value");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               blank_q, blank_d;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic [CHAR_W-1:0]  out_char_q, out_char_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_next;
  logic [CHAR_W-1:0]  glyphs;
  logic               leading;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    dd_add3 u_add3 (
      .digit    (bcd_q[4*i +: 4]),
      .adjusted (bcd_adj[4*i +: 4])
    );
  end

  // The bit shifted out of the top digit is always zero given the digit check.
  assign bcd_next = BCD_W'({bcd_adj, shift_q[WIDTH-1]});

  // Glyphs for the result being completed this cycle, scanned from the top digit.
  always_comb begin
    glyphs  = '0;
    leading = blank_q;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (leading && (bcd_next[4*i +: 4] == 4'd0) && (i != 0)) begin
        glyphs[ADDR_W*i +: ADDR_W] = BLANK_CODE;
      end else begin
        glyphs[ADDR_W*i +: ADDR_W] = ADDR_W'(digit_glyph(32'(ZERO_CODE), bcd_next[4*i +: 4]));
        leading = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    blank_d    = blank_q;
    out_bcd_d  = out_bcd_q;
    out_char_d = out_char_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = in_value;
          blank_d = in_blank_lz;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        bcd_d   = bcd_next;
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          out_bcd_d  = bcd_next;
          out_char_d = glyphs;
          state_d    = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      blank_q    <= 1'b0;
      out_bcd_q  <= '0;
      out_char_q <= {DIGITS{BLANK_CODE}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      blank_q    <= blank_d;
      out_bcd_q  <= out_bcd_d;
      out_char_q <= out_char_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StShift);
  assign out_valid = (state_q == StHold);
  assign out_bcd   = out_bcd_q;
  assign out_char  = out_char_q;

endmodule
